// File: rtl/sa_cache_ctrl_if.sv
// CPU, tag/data array and memory signals of the set-associative cache controller.
// slave: the controller itself; master: the CPU/array/memory side driving it.
interface sa_cache_ctrl_if #(
   parameter int IDX_W  = 4,
   parameter int BEAT_W = 2
);
   logic              cpu_req_valid;
   logic              cpu_req_we;
   logic [IDX_W-1:0]  cpu_req_idx;
   logic              cpu_req_ready;
   logic              cpu_resp_valid;
   logic              arr_rd;
   logic [IDX_W-1:0]  arr_idx;
   logic [3:0]        tag_hit;
   logic [3:0]        way_valid;
   logic [3:0]        way_dirty;
   logic [1:0]        arr_way;
   logic [BEAT_W-1:0] arr_beat;
   logic              arr_data_we;
   logic              arr_tag_we;
   logic              arr_dirty_set;
   logic              mem_req_valid;
   logic              mem_req_we;
   logic              mem_req_ready;
   logic              mem_wvalid;
   logic              mem_wready;
   logic              mem_rvalid;
   logic              err_multihit;

   modport slave (
      input  cpu_req_valid, cpu_req_we, cpu_req_idx, tag_hit, way_valid, way_dirty,
             mem_req_ready, mem_wready, mem_rvalid,
      output cpu_req_ready, cpu_resp_valid, arr_rd, arr_idx, arr_way, arr_beat,
             arr_data_we, arr_tag_we, arr_dirty_set, mem_req_valid, mem_req_we,
             mem_wvalid, err_multihit
   );

   modport master (
      output cpu_req_valid, cpu_req_we, cpu_req_idx, tag_hit, way_valid, way_dirty,
             mem_req_ready, mem_wready, mem_rvalid,
      input  cpu_req_ready, cpu_resp_valid, arr_rd, arr_idx, arr_way, arr_beat,
             arr_data_we, arr_tag_we, arr_dirty_set, mem_req_valid, mem_req_we,
             mem_wvalid, err_multihit
   );
endinterface

// File: rtl/sa_cache_ctrl.sv
// 4-way cache sequencer: lookup, victim select (invalid first, else tree-PLRU), writeback, refill, replay.
// Hit: accept->resp 2 cycles; miss adds writeback/refill time set by memory handshakes.
// One request in flight: cpu_req_ready only in IDLE; memory phases stall on mem_req_ready/mem_wready/mem_rvalid.
module sa_cache_ctrl #(
   parameter int IDX_W = 4,
   parameter int BEATS = 4
) (
   input  logic             clk,
   input  logic             rst,
   sa_cache_ctrl_if.slave   bus
);
   localparam int SETS   = 1 << IDX_W;
   localparam int BEAT_W = $clog2(BEATS);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA, RESP
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q;
   logic              we_q;
   logic [1:0]        way_q, way_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [2:0]        plru_q [SETS];
   logic              err_q;

   logic              plru_upd;
   logic              multihit;
   logic [2:0]        plru_cur, plru_next;
   logic [1:0]        hit_way, inv_way, plru_vict, victim;
   logic              victim_dirty;
   logic              last_beat;

   function automatic logic [1:0] lowest(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   always_comb begin
      plru_cur     = plru_q[idx_q];
      hit_way      = lowest(bus.tag_hit);
      inv_way      = lowest(~bus.way_valid);
      // b0 picks the pair, then b1 (ways 0/1) or b2 (ways 2/3) picks within it
      plru_vict    = {plru_cur[0], plru_cur[0] ? plru_cur[2] : plru_cur[1]};
      victim       = (&bus.way_valid) ? plru_vict : inv_way;
      victim_dirty = bus.way_valid[victim] & bus.way_dirty[victim];
      last_beat    = (beat_q == BEAT_W'(BEATS - 1));
      plru_next    = plru_cur;
      plru_next[0] = ~hit_way[1];
      if (!hit_way[1]) plru_next[1] = ~hit_way[0];
      else             plru_next[2] = ~hit_way[0];
   end

   always_comb begin
      state_d            = state_q;
      way_d              = way_q;
      beat_d             = beat_q;
      plru_upd           = 1'b0;
      multihit           = 1'b0;
      bus.cpu_req_ready  = 1'b0;
      bus.cpu_resp_valid = 1'b0;
      bus.arr_rd         = 1'b0;
      bus.arr_idx        = idx_q;
      bus.arr_way        = way_q;
      bus.arr_beat       = beat_q;
      bus.arr_data_we    = 1'b0;
      bus.arr_tag_we     = 1'b0;
      bus.arr_dirty_set  = 1'b0;
      bus.mem_req_valid  = 1'b0;
      bus.mem_req_we     = 1'b0;
      bus.mem_wvalid     = 1'b0;
      case (state_q)
         IDLE: begin
            bus.cpu_req_ready = 1'b1;
            if (bus.cpu_req_valid) begin
               bus.arr_rd  = 1'b1;
               bus.arr_idx = bus.cpu_req_idx;
               state_d     = LOOKUP;
            end
         end
         LOOKUP: begin
            if (|bus.tag_hit) begin
               bus.arr_way       = hit_way;
               way_d             = hit_way;
               plru_upd          = 1'b1;
               bus.arr_data_we   = we_q;
               bus.arr_dirty_set = we_q;
               multihit          = (bus.tag_hit & (bus.tag_hit - 4'd1)) != 4'd0;
               state_d           = RESP;
            end else begin
               bus.arr_way = victim;
               way_d       = victim;
               state_d     = victim_dirty ? WB_REQ : RF_REQ;
            end
         end
         WB_REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_we    = 1'b1;
            if (bus.mem_req_ready) begin
               state_d = WB_DATA;
               beat_d  = '0;
            end
         end
         WB_DATA: begin
            bus.mem_wvalid = 1'b1;
            if (bus.mem_wready) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) state_d = RF_REQ;
            end
         end
         RF_REQ: begin
            bus.mem_req_valid = 1'b1;
            if (bus.mem_req_ready) begin
               state_d = RF_DATA;
               beat_d  = '0;
            end
         end
         RF_DATA: begin
            if (bus.mem_rvalid) begin
               bus.arr_data_we = 1'b1;
               beat_d          = beat_q + 1'b1;
               if (last_beat) begin
                  // replay the lookup so the refilled way is taken as a normal hit
                  bus.arr_tag_we = 1'b1;
                  bus.arr_rd     = 1'b1;
                  state_d        = LOOKUP;
               end
            end
         end
         RESP: begin
            bus.cpu_resp_valid = 1'b1;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.err_multihit = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         we_q    <= 1'b0;
         way_q   <= 2'd0;
         beat_q  <= '0;
         err_q   <= 1'b0;
         for (int s = 0; s < SETS; s++) plru_q[s] <= 3'b000;
      end else begin
         state_q <= state_d;
         way_q   <= way_d;
         beat_q  <= beat_d;
         if (state_q == IDLE && bus.cpu_req_valid) begin
            idx_q <= bus.cpu_req_idx;
            we_q  <= bus.cpu_req_we;
         end
         if (multihit) err_q <= 1'b1;
         if (plru_upd) plru_q[idx_q] <= plru_next;
      end
   end
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Scoreboard bench for sa_cache_ctrl: behavioural tag/state array and memory responder around the controller.
module tb_sa_cache_ctrl;
   localparam int IDX_W  = 4;
   localparam int BEATS  = 4;
   localparam int BEAT_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sa_cache_ctrl_if #(.IDX_W(IDX_W), .BEAT_W(BEAT_W)) bus ();
   sa_cache_ctrl #(.IDX_W(IDX_W), .BEATS(BEATS)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [1:0] way;
      logic       we;
      int         wb;
      int         rf;
      int         lat;
      logic       err;
   } exp_t;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // array model and stimulus mailbox
   logic [3:0] m_valid [16] = '{default: 4'h0};
   logic [3:0] m_dirty [16] = '{default: 4'h0};
   logic [2:0] m_plru  [16] = '{default: 3'b000};
   logic [3:0] cur_hit = 4'h0;
   assign bus.tag_hit   = cur_hit;
   assign bus.way_valid = m_valid[bus.arr_idx];
   assign bus.way_dirty = m_dirty[bus.arr_idx];

   int         r_seq = 0, r_done = 0;
   logic [3:0] r_idx, r_valid, r_dirty, r_hit;
   logic       r_we;
   int         req_stall = 0;
   bit         gap_en = 1'b0;

   exp_t       sb_q [$];
   exp_t       e, e_pop;
   logic       exp_err = 1'b0;
   int         cyc = 0, acc_cyc = 0, req_wait = 0;
   int         wb_cnt = 0, rf_cnt = 0, resp_cnt = 0, stall_seen = 0, last_lat = 0;
   bit         busy = 0, req_acc = 0, rf_active = 0, prev_stall = 0;
   bit         pend_tag = 0, pend_dirty = 0;
   logic [3:0] pt_idx, pd_idx;
   logic [1:0] pt_way, pd_way, prev_way, last_way;
   logic       prev_dwe, prev_dset, prev_we;

   function automatic logic [1:0] low_bit(input logic [3:0] v);
      for (int i = 3; i >= 0; i--) if (v[i]) low_bit = 2'(i);
   endfunction

   function automatic logic [1:0] plru_victim(input logic [2:0] p);
      case ({p[0], p[1], p[2]})
         3'b000, 3'b001: plru_victim = 2'd0;
         3'b010, 3'b011: plru_victim = 2'd1;
         3'b100, 3'b110: plru_victim = 2'd2;
         default:        plru_victim = 2'd3;
      endcase
   endfunction

   function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
      logic [2:0] n;
      n = p;
      case (w)
         2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
         2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
         2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
         default: begin n[0] = 1'b0; n[2] = 1'b0; end
      endcase
      return n;
   endfunction

   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
         for (int s = 0; s < 16; s++) m_plru[s] = 3'b000;
         sb_q.delete();
         {rf_active, busy, req_acc, pend_tag, pend_dirty, prev_stall} = '0;
         exp_err = 1'b0;
         bus.cpu_req_valid = 1'b0; bus.cpu_req_we = 1'b0; bus.cpu_req_idx = '0;
         bus.mem_req_ready = 1'b0; bus.mem_wready = 1'b0; bus.mem_rvalid = 1'b0;
         r_done = r_seq;
      end else begin
         if (pend_tag) begin
            m_valid[pt_idx][pt_way] = 1'b1;
            m_dirty[pt_idx][pt_way] = 1'b0;
            cur_hit[pt_way] = 1'b1;
            pend_tag = 0;
         end
         if (pend_dirty) begin
            m_dirty[pd_idx][pd_way] = 1'b1;
            pend_dirty = 0;
         end
         if (req_acc) begin
            bus.cpu_req_valid = 1'b0;
            req_acc = 0;
         end
         if (r_seq != r_done && !busy) begin
            m_valid[r_idx] = r_valid; m_dirty[r_idx] = r_dirty; cur_hit = r_hit;
            bus.cpu_req_valid = 1'b1; bus.cpu_req_we = r_we; bus.cpu_req_idx = r_idx;
            e.we = r_we;
            if (r_hit != 4'h0) begin
               e.way = low_bit(r_hit); e.wb = 0; e.rf = 0; e.lat = 2;
               if ((r_hit & (r_hit - 4'd1)) != 4'h0) exp_err = 1'b1;
            end else begin
               e.way = (r_valid != 4'hF) ? low_bit(~r_valid) : plru_victim(m_plru[r_idx]);
               e.wb  = (r_valid[e.way] && r_dirty[e.way]) ? BEATS : 0;
               e.rf  = BEATS; e.lat = 0;
            end
            e.err = exp_err;
            m_plru[r_idx] = plru_touch(m_plru[r_idx], e.way);
            sb_q.push_back(e);
            r_done = r_seq;
            busy = 1;
         end
         if (!bus.mem_req_valid) begin
            req_wait = req_stall;
            bus.mem_req_ready = 1'b0;
         end else if (req_wait > 0) begin
            req_wait--;
            bus.mem_req_ready = 1'b0;
         end else bus.mem_req_ready = 1'b1;
         bus.mem_wready = bus.mem_wvalid && (!gap_en || $urandom_range(0, 1) == 1);
         bus.mem_rvalid = rf_active && (!gap_en || $urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      if (rst) begin
         if (bus.cpu_req_valid && bus.cpu_req_ready) begin
            check("acc_rd", bus.arr_rd, 1);
            check("acc_idx", bus.arr_idx, r_idx);
            acc_cyc = cyc; wb_cnt = 0; rf_cnt = 0; req_acc = 1;
         end
         if (prev_stall) begin
            check("req_hold_vld", bus.mem_req_valid, 1);
            check("req_hold_we", bus.mem_req_we, prev_we);
         end
         prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
         prev_we    = bus.mem_req_we;
         if (prev_stall) stall_seen++;
         if (bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_we) rf_active = 1;
         if (bus.mem_wvalid) begin
            check("wb_beat", bus.arr_beat, wb_cnt % BEATS);
            if (sb_q.size() > 0) check("wb_way", bus.arr_way, sb_q[0].way);
            if (bus.mem_wready) wb_cnt++;
         end
         if (rf_active && bus.mem_rvalid) begin
            check("rf_dwe", bus.arr_data_we, 1);
            check("rf_beat", bus.arr_beat, rf_cnt % BEATS);
            rf_cnt++;
            check("rf_tag_we", bus.arr_tag_we, rf_cnt == BEATS);
            if (rf_cnt == BEATS) begin
               check("rf_replay_rd", bus.arr_rd, 1);
               pend_tag = 1; pt_idx = bus.arr_idx; pt_way = bus.arr_way;
               rf_active = 0;
            end
         end
         if (bus.arr_dirty_set) begin
            pend_dirty = 1; pd_idx = bus.arr_idx; pd_way = bus.arr_way;
         end
         if (bus.cpu_resp_valid) begin
            resp_cnt++;
            busy = 0;
            if (sb_q.size() == 0) check("spurious_resp", 1, 0);
            else begin
               e_pop = sb_q.pop_front();
               check("resp_way", prev_way, e_pop.way);
               check("resp_dwe", prev_dwe, e_pop.we);
               check("resp_dset", prev_dset, e_pop.we);
               check("resp_wb_beats", wb_cnt, e_pop.wb);
               check("resp_rf_beats", rf_cnt, e_pop.rf);
               check("resp_err", bus.err_multihit, e_pop.err);
               if (e_pop.lat > 0) check("resp_lat", cyc - acc_cyc, e_pop.lat);
            end
            last_way = prev_way;
            last_lat = cyc - acc_cyc;
         end
         prev_way = bus.arr_way; prev_dwe = bus.arr_data_we; prev_dset = bus.arr_dirty_set;
      end
   end

   task automatic send(input logic [3:0] idx, input logic we, input logic [3:0] valid,
                       input logic [3:0] dirty, input logic [3:0] hit);
      r_idx = idx; r_we = we; r_valid = valid; r_dirty = dirty; r_hit = hit;
      r_seq++;
   endtask

   task automatic do_req(input logic [3:0] idx, input logic we, input logic [3:0] valid,
                         input logic [3:0] dirty, input logic [3:0] hit);
      int base;
      base = resp_cnt;
      send(idx, we, valid, dirty, hit);
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         if (resp_cnt != base) break;
      end
      check("resp_seen", resp_cnt != base, 1);
      @(posedge clk);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_ready"}, bus.cpu_req_ready, 1);
      check({tag, "_outs"}, {bus.cpu_resp_valid, bus.arr_rd, bus.arr_idx, bus.arr_way, bus.arr_beat,
                             bus.arr_data_we, bus.arr_tag_we, bus.arr_dirty_set, bus.mem_req_valid,
                             bus.mem_req_we, bus.mem_wvalid, bus.err_multihit}, 0);
   endtask

   int base_r, base_s;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk_reset("rst0");
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // reset while refilling: abort, no response afterwards
      gap_en = 1'b1;
      send(4'd1, 1'b0, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (rf_cnt >= 2) break;
      end
      check("t1_reached_rf", rf_cnt >= 2, 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_reset("t1_rst");
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      gap_en = 1'b0;
      base_r = resp_cnt;
      repeat (12) @(posedge clk);
      check("t1_no_resp", resp_cnt - base_r, 0);

      // cold miss refill into way 0, then PLRU must point at way 2
      do_req(4'd3, 1'b0, 4'h0, 4'h0, 4'h0);
      check("t2_way", last_way, 0);
      do_req(4'd3, 1'b0, 4'hF, 4'h0, 4'h0);
      check("t2_plru_vict", last_way, 2);

      // full dirty set, PLRU 000: writeback way 0 then refill
      do_req(4'd5, 1'b0, 4'hF, 4'hF, 4'h0);
      check("t3_way", last_way, 0);

      // write hit on way 2
      do_req(4'd9, 1'b1, 4'hF, 4'h0, 4'h4);
      check("t4_way", last_way, 2);
      check("t4_lat", last_lat, 2);

      // stalled command handshakes and beat gaps, then multi-hit
      req_stall = 10;
      gap_en = 1'b1;
      base_s = stall_seen;
      do_req(4'd7, 1'b0, 4'hF, 4'hF, 4'h0);
      check("t5_stall_cycles", stall_seen - base_s, 20);
      req_stall = 0;
      gap_en = 1'b0;
      do_req(4'd7, 1'b0, 4'hF, 4'h0, 4'h3);
      check("t5_mh_way", last_way, 0);
      do_req(4'd9, 1'b0, 4'hF, 4'h0, 4'h1);
      check("t5_err_sticky", bus.err_multihit, 1);

      // PLRU after hits to ways 0,2,1,3
      do_req(4'd12, 1'b0, 4'hF, 4'h0, 4'h1);
      do_req(4'd12, 1'b0, 4'hF, 4'h0, 4'h4);
      do_req(4'd12, 1'b0, 4'hF, 4'h0, 4'h2);
      do_req(4'd12, 1'b0, 4'hF, 4'h0, 4'h8);
      do_req(4'd12, 1'b1, 4'hF, 4'h0, 4'h0);
      check("t6_victim", last_way, 0);

      check("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
